alu_exec_unit: RTL
==================

# alu_exec_unit

Execute-stage arithmetic unit sitting directly downstream of the ALU controller: consumes the 4-bit `Operation` code it produces plus the two operands, and returns a registered 32-bit result with a zero flag. Single-cycle operations complete in one cycle. An iterative unsigned multiplier/divider takes 32 cycles per operation and uses the otherwise-free codes 1011–1110. A valid/ready handshake on both sides lets the pipeline stall while a long operation runs.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `Operation`/`SrcA`/`SrcB` valid this cycle.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `Operation` in 4: operation code from the ALU controller.
- `SrcA` in WIDTH: operand A.
- `SrcB` in WIDTH: operand B; shift amount is `SrcB[4:0]`.
- `out_valid` out 1: `Result`/`Zero` valid; held until accepted.
- `out_ready` in 1: consumer accepts the result.
- `Result` out WIDTH: registered result.
- `Zero` out 1: registered, equals (`Result` == 0).

## Operation
- Codes:
  - 0000 ADD; 0001 SUB; 0010 XOR; 0011 OR; 0100 AND.
  - 0101 SRL; 0110 SLL; 0111 SRA (arithmetic).
  - 1000 SLT (signed, result 0/1); 1001 SLTU (unsigned, 0/1).
  - 1010 BEQ: Result = {0…, SrcA==SrcB}.
  - 1011 MUL: low WIDTH bits of the unsigned product.
  - 1100 MULHU: high WIDTH bits of the unsigned product.
  - 1101 DIVU: quotient; 1110 REMU: remainder.
  - 1111 reserved: Result = 0, single-cycle.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- Accept happens when `in_valid && in_ready`. Operands and code are captured into internal registers on accept; input changes afterwards are ignored.
- FSM states are IDLE, MUL, DIV, DONE.
  - IDLE: on accept of codes 0000–1010 or 1111, compute and register `Result`, then go to DONE. On 1011/1100 go to MUL; on 1101/1110 go to DIV. Without accept, stay in IDLE.
  - MUL: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first. 5-bit counter runs 0..31; after count 31, load the selected half into `Result` and go to DONE.
  - DIV: restoring division, one quotient bit per cycle, MSB first. Same counter; after count 31, load the quotient or remainder and go to DONE.
  - DONE: `out_valid`=1. If `out_ready`, go to IDLE; otherwise hold with `Result`/`Zero` stable.
- Division by zero:
  - DIVU → all ones; REMU → SrcA.
  - Still takes the full 32 iterations; no special fast path.
- No accept in DONE, even when `out_ready` is high: at most one operation in flight.
- `Zero` is updated in the same cycle as `Result`, never combinationally from inputs.

## Timing
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `Result`=0, `Zero`=1, counter 0, internal operand registers 0.
- Reset asserted mid-MUL/DIV/DONE aborts the operation. The next cycle shows reset values; the partial result is discarded.
- Single-cycle ops: accept at edge N, `out_valid`=1 after edge N+1.
- MUL/DIV ops: accept at edge N, `out_valid`=1 after edge N+33 (32 iteration cycles plus a load into DONE).
- `in_ready` drops the cycle after accept and returns the cycle after the result handshake.
- Back-to-back throughput for single-cycle ops is one op per 2 cycles: accept, DONE, then IDLE again.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1 with `out_ready`=1 → after 1 cycle `Result`=0x80000000, `Zero`=0. SUB 5−5 → `Result`=0, `Zero`=1.
- SRA 0x80000000 by `SrcB`=0x24 (shamt 4) → 0xF8000000. SLT 0xFFFFFFFF,1 → 1. SLTU same operands → 0. BEQ 7,7 → 1.
- MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001; MULHU same → 0xFFFFFFFE. `out_valid` rises exactly 33 cycles after accept and `in_ready`=0 throughout.
- DIVU 100/7 → 14, REMU → 2. DIVU x/0 with x=0x1234 → 0xFFFFFFFF; REMU x/0 → 0x1234.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE with `in_valid`=1 and changing inputs → `Result` stable, no accept. Release → IDLE, and the new op is accepted the next cycle.
- Assert `reset` at iteration 15 of a DIVU → next cycle IDLE with `Result`=0, `Zero`=1, `out_valid`=0. A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU with single-cycle ops plus an iterative
//            unsigned multiplier/divider, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     b_q;
  // Shared accumulator: {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   acc_q;

  logic                 accept;
  logic [WIDTH-1:0]     alu_d;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_d;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_d;
  logic [WIDTH-1:0]     fin_d;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;

  // Single-cycle operations, evaluated straight from the inputs at accept
  always_comb begin
    alu_d = '0;
    case (Operation)
      OP_ADD:  alu_d = SrcA + SrcB;
      OP_SUB:  alu_d = SrcA - SrcB;
      OP_XOR:  alu_d = SrcA ^ SrcB;
      OP_OR:   alu_d = SrcA | SrcB;
      OP_AND:  alu_d = SrcA & SrcB;
      OP_SRL:  alu_d = SrcA >> SrcB[4:0];
      OP_SLL:  alu_d = SrcA << SrcB[4:0];
      OP_SRA:  alu_d = $signed(SrcA) >>> SrcB[4:0];
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_BEQ:  alu_d = {{(WIDTH-1){1'b0}}, (SrcA == SrcB)};
      default: alu_d = '0;
    endcase
  end

  // Shift-add step: add B to the upper half when the current multiplier LSB is set, then shift right
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_d   = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: shift the next dividend bit into the remainder, keep the trial subtraction if no borrow.
  // A zero divisor never borrows, which naturally yields all-ones quotient and remainder == dividend.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_d     = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // Final half selection for the iterative unit, taken from the last step's value
  always_comb begin
    fin_d = '0;
    case (op_q)
      OP_MUL:   fin_d = mul_d[WIDTH-1:0];
      OP_MULHU: fin_d = mul_d[2*WIDTH-1:WIDTH];
      OP_DIVU:  fin_d = div_d[WIDTH-1:0];
      OP_REMU:  fin_d = div_d[2*WIDTH-1:WIDTH];
      default:  fin_d = '0;
    endcase
  end

  // Control FSM with registered handshake outputs and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      cnt_q       <= '0;
      op_q        <= '0;
      b_q         <= '0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q       <= Operation;
            b_q        <= SrcB;
            acc_q      <= {{WIDTH{1'b0}}, SrcA};
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (Operation == OP_MUL || Operation == OP_MULHU) begin
              state_q <= S_MUL;
            end else if (Operation == OP_DIVU || Operation == OP_REMU) begin
              state_q <= S_DIV;
            end else begin
              result_q    <= alu_d;
              zero_q      <= (alu_d == '0);
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= (state_q == S_MUL) ? mul_d : div_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_q    <= fin_d;
            zero_q      <= (fin_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
